decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter N, default 3: select width; output is 2**N one-hot lines; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 4: clock cycles each line is held in scan mode; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ena, input, 1: global enable; low forces out to all-zero and freezes state.
REQ-006 SHALL have port mode, input, 1: 0 = DIRECT (decode accepted input), 1 = SCAN (auto-sweep lines).
REQ-007 SHALL have port in, input, N: select value offered in DIRECT mode.
REQ-008 SHALL have port in_valid, input, 1: in is valid this cycle.
REQ-009 SHALL have port in_ready, output, 1: block accepts in this cycle.
REQ-010 SHALL have port out, output, 2**N: registered one-hot decode of sel, or zero.
REQ-011 SHALL have port sel, output, N: current registered select index.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse when SCAN steps sel from 2**N-1 to 0.

Function
REQ-013 SHALL implement FSM with states S_DIRECT and S_SCAN; state is S_SCAN iff registered mode is 1.
REQ-014 SHALL sample mode each enabled cycle; a change takes effect next cycle, with the dwell counter cleared and sel unchanged.
REQ-015 SHALL drive out = (1 << sel) when ena is high and the block is out of reset; otherwise out = 0.
REQ-016 SHALL assert in_ready = ena AND (state == S_DIRECT); combinational from registered state and ena only, never from in_valid.
REQ-017 SHALL, on in_valid AND in_ready at a rising edge, load sel <= in; out reflects the new value one cycle later (latency 1).
REQ-018 SHALL hold sel unchanged in S_DIRECT when no transfer occurs.
REQ-019 SHALL, in S_SCAN, count dwell 0..DWELL-1; on the cycle dwell == DWELL-1, set sel <= sel+1 modulo 2**N and dwell <= 0.
REQ-020 SHALL, with DWELL = 1, advance sel every enabled cycle.
REQ-021 SHALL assert wrap for exactly the one cycle after sel changes from 2**N-1 to 0 in S_SCAN; never in S_DIRECT.
REQ-022 SHALL, with ena low, freeze sel, dwell and state, force in_ready = 0 and wrap = 0, and resume from the frozen values when ena returns high.
REQ-023 SHALL ignore in_valid while in S_SCAN; no buffering of offered inputs.
REQ-024 SHALL size the dwell counter as $clog2(DWELL) bits, minimum 1 bit, with no overflow past DWELL-1.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force state = S_DIRECT, sel = 0, dwell = 0, out = 0, wrap = 0, in_ready = 0.
REQ-026 SHALL, on rst_n deasserting mid-scan, restart from sel = 0 with a full DWELL period before the first step.

Structure
REQ-027 SHALL place the FSM state enum and the MODE_DIRECT/MODE_SCAN constants in shared package decoder_pkg.
REQ-028 SHALL instantiate one combinational sub-module, decoder_onehot (parameter N; ports ena, in, out), to produce out from sel and ena.
REQ-029 SHALL keep sel, dwell, state and wrap as the only registered state.

Verification
REQ-030 SHALL cover DIRECT with N=3: ena=1, mode=0, in=5 with in_valid for 1 cycle -> next cycle sel=5, out=8'b0010_0000, in_ready=1.
REQ-031 SHALL cover SCAN with N=3, DWELL=4 from sel=6: sel changes to 7 after 4 cycles, then to 0 after 4 more; wrap high for exactly 1 cycle at sel=0.
REQ-032 SHALL cover ena low for 3 cycles mid-dwell in SCAN: out=0, in_ready=0, and the remaining dwell count resumes unchanged after ena rises.
REQ-033 SHALL cover mode 0->1->0 with in_valid held high: in ignored while in SCAN, in_ready=0; sel retained across switches; new in accepted after return to DIRECT.
REQ-034 SHALL cover rst_n pulsed low asynchronously mid-scan at sel=3: out=0 immediately; after release sel=0 and the first step occurs DWELL cycles later.
REQ-035 SHALL cover DWELL=1, N=1: sel toggles 0,1,0 every cycle with wrap on each 1->0 step.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the line decoder / scanner.
//   state_e       : controller state (direct decode or automatic sweep)
//   MODE_DIRECT/  : encodings of the mode input
//   MODE_SCAN
//   dwell_width() : dwell counter width, never narrower than one bit
package decoder_pkg;

    typedef enum logic [0:0] {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int dwell_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational one-hot decoder with enable.
//   ena : high drives a single line, low forces all lines to zero
//   in  : line index, N bits
//   out : 2**N one-hot lines
module decoder_onehot #(
    parameter int N = 3
) (
    input  logic             ena,
    input  logic [N-1:0]     in,
    output logic [2**N-1:0]  out
);

    always_comb begin
        out = '0;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// One-hot line driver with two modes: DIRECT decodes a select value
// accepted over a valid/ready handshake, SCAN sweeps every line in turn,
// holding each for DWELL cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_DIRECT | sel loads from in on in_valid & in_ready, otherwise holds
// S_SCAN   | sel advances every DWELL cycles, wrap pulses on 2**N-1 -> 0
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; low blanks out and freezes all state
//   mode       : 0 = DIRECT, 1 = SCAN (takes effect one cycle later)
//   in/in_valid/in_ready : select handshake, accepted only in DIRECT
//   out        : one-hot decode of sel, zero when disabled or in reset
//   sel        : current select index
//   wrap       : one-cycle pulse after a scan wraps back to line 0
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             mode,
    input  logic [N-1:0]     in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2**N-1:0]  out,
    output logic [N-1:0]     sel,
    output logic             wrap
);

    localparam int            DW         = dwell_width(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]  SEL_MAX    = '1;

    state_e         state_q, state_d;
    state_e         mode_state;
    logic [N-1:0]   sel_q, sel_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic           wrap_q, wrap_d;
    logic           drive_en;

    always_comb begin
        mode_state = (mode == MODE_SCAN) ? S_SCAN : S_DIRECT;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        if (ena) begin
            state_d = mode_state;
            if (state_q == S_DIRECT) begin
                // in_ready is high whenever we get here, so in_valid alone
                // completes the handshake
                dwell_d = '0;
                if (in_valid) begin
                    sel_d = in;
                end
            end else if (mode_state != state_q) begin
                // leaving SCAN: hold the current line, restart the dwell
                dwell_d = '0;
            end else if (dwell_q == DWELL_LAST) begin
                sel_d   = sel_q + 1'b1;
                dwell_d = '0;
                wrap_d  = (sel_q == SEL_MAX);
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DIRECT;
            sel_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
        end
    end

    // sel resets to 0, so the decoder must also be blanked by rst_n to keep
    // out at zero while reset is held
    assign drive_en = ena & rst_n;

    decoder_onehot #(
        .N (N)
    ) u_onehot (
        .ena (drive_en),
        .in  (sel_q),
        .out (out)
    );

    assign in_ready = drive_en & (state_q == S_DIRECT);
    assign sel      = sel_q;
    assign wrap     = wrap_q & ena;

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       ena;
    logic       mode;
    logic [2:0] in_a;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_a;
    logic [2:0] sel_a;
    logic       wrap_a;

    logic       ena_b;
    logic       mode_b;
    logic [0:0] in_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic [1:0] out_b;
    logic [0:0] sel_b;
    logic       wrap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_scan #(.N(3), .DWELL(4)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .mode     (mode),
        .in       (in_a),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out_a),
        .sel      (sel_a),
        .wrap     (wrap_a)
    );

    decoder_scan #(.N(1), .DWELL(1)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena_b),
        .mode     (mode_b),
        .in       (in_b),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .out      (out_b),
        .sel      (sel_b),
        .wrap     (wrap_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        mode       = 1'b0;
        in_a       = 3'd0;
        in_valid   = 1'b0;
        ena_b      = 1'b1;
        mode_b     = 1'b0;
        in_b       = 1'b0;
        in_valid_b = 1'b0;

        // reset held
        #2;
        chk("rst_out",      64'(out_a),    64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_sel",      64'(sel_a),    64'h0);
        chk("rst_wrap",     64'(wrap_a),   64'h0);
        #10 rst_n = 1'b1;
        tick(1);
        chk("idle_out",      64'(out_a),    64'h01);
        chk("idle_in_ready", 64'(in_ready), 64'h1);

        // DIRECT load of 5
        in_a = 3'd5; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0; in_a = 3'd2;
        chk("direct_sel",      64'(sel_a),    64'd5);
        chk("direct_out",      64'(out_a),    64'h20);
        chk("direct_in_ready", 64'(in_ready), 64'h1);
        tick(2);
        chk("direct_hold", 64'(sel_a), 64'd5);

        in_a = 3'd6; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("direct_sel6", 64'(sel_a), 64'd6);

        // SCAN from 6, DWELL=4
        mode = 1'b1;
        tick(1);
        chk("scan_in_ready", 64'(in_ready), 64'h0);
        chk("scan_sel_keep", 64'(sel_a),    64'd6);
        tick(3);
        chk("scan_sel6_dwell", 64'(sel_a), 64'd6);
        tick(1);
        chk("scan_sel7",  64'(sel_a),  64'd7);
        chk("scan_wrap7", 64'(wrap_a), 64'h0);
        tick(3);
        chk("scan_sel7_dwell", 64'(sel_a), 64'd7);
        tick(1);
        chk("scan_sel0",  64'(sel_a),  64'd0);
        chk("scan_wrap",  64'(wrap_a), 64'h1);
        chk("scan_out0",  64'(out_a),  64'h01);
        tick(1);
        chk("scan_wrap_end", 64'(wrap_a), 64'h0);

        // ena low mid-dwell (dwell = 2 after this tick)
        tick(1);
        ena = 1'b0;
        #1;
        chk("ena_out",      64'(out_a),    64'h0);
        chk("ena_in_ready", 64'(in_ready), 64'h0);
        tick(3);
        chk("ena_sel_frozen", 64'(sel_a), 64'd0);
        chk("ena_out_hold",   64'(out_a), 64'h0);
        ena = 1'b1;
        tick(1);
        chk("ena_resume_hold", 64'(sel_a), 64'd0);
        tick(1);
        chk("ena_resume_step", 64'(sel_a), 64'd1);

        // mode switches with in_valid offered
        in_a = 3'd4; in_valid = 1'b1;
        tick(1);
        chk("scan_ignore_sel",   64'(sel_a),    64'd1);
        chk("scan_ignore_ready", 64'(in_ready), 64'h0);
        mode = 1'b0;
        tick(1);
        chk("back_direct_sel",   64'(sel_a),    64'd1);
        chk("back_direct_ready", 64'(in_ready), 64'h1);
        tick(1);
        chk("back_direct_load", 64'(sel_a), 64'd4);
        in_valid = 1'b0; mode = 1'b1;
        tick(1);
        chk("rescan_sel", 64'(sel_a), 64'd4);
        in_a = 3'd7; in_valid = 1'b1;
        tick(1);
        chk("rescan_ignore", 64'(sel_a), 64'd4);
        mode = 1'b0;
        tick(1);
        chk("redirect_sel", 64'(sel_a), 64'd4);
        tick(1);
        chk("redirect_load", 64'(sel_a), 64'd7);

        // async reset mid-scan at sel=3
        in_a = 3'd3;
        tick(1);
        in_valid = 1'b0;
        chk("pre_rst_sel", 64'(sel_a), 64'd3);
        mode = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("arst_out", 64'(out_a),    64'h0);
        chk("arst_sel", 64'(sel_a),    64'd0);
        chk("arst_rdy", 64'(in_ready), 64'h0);
        tick(1);
        rst_n = 1'b1;
        #1;
        chk("post_rst_sel", 64'(sel_a), 64'd0);
        chk("post_rst_out", 64'(out_a), 64'h01);
        tick(4);
        chk("post_rst_dwell", 64'(sel_a), 64'd0);
        tick(1);
        chk("post_rst_step", 64'(sel_a), 64'd1);

        // N=1, DWELL=1 scan
        chk("b_ready_direct", 64'(in_ready_b), 64'h1);
        mode_b = 1'b1;
        tick(1);
        chk("b_ready_scan", 64'(in_ready_b), 64'h0);
        chk("b_sel0",       64'(sel_b),      64'd0);
        tick(1);
        chk("b_sel1",  64'(sel_b),  64'd1);
        chk("b_out1",  64'(out_b),  64'h2);
        chk("b_wrap1", 64'(wrap_b), 64'h0);
        tick(1);
        chk("b_sel0b",  64'(sel_b),  64'd0);
        chk("b_wrap0b", 64'(wrap_b), 64'h1);
        chk("b_out0b",  64'(out_b),  64'h1);
        tick(1);
        chk("b_sel1b",  64'(sel_b),  64'd1);
        chk("b_wrap1b", 64'(wrap_b), 64'h0);
        tick(1);
        chk("b_sel0c",  64'(sel_b),  64'd0);
        chk("b_wrap0c", 64'(wrap_b), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
